// File: rtl/generador_datos_if.sv
// generador_datos_if: per-lane word/valid/ready bundle of the four-lane word source.
//   data_out_0..3 : lane words {lane_id, seq}    (master -> slave)
//   valid_0..3    : lane word valid              (master -> slave)
//   ready_0..3    : lane sink ready              (slave -> master)
interface generador_datos_if #(
  parameter int unsigned DATA_W = 10
);
  logic [DATA_W-1:0] data_out_0;
  logic [DATA_W-1:0] data_out_1;
  logic [DATA_W-1:0] data_out_2;
  logic [DATA_W-1:0] data_out_3;
  logic              valid_0;
  logic              valid_1;
  logic              valid_2;
  logic              valid_3;
  logic              ready_0;
  logic              ready_1;
  logic              ready_2;
  logic              ready_3;

  modport master (
    output data_out_0, data_out_1, data_out_2, data_out_3,
    output valid_0, valid_1, valid_2, valid_3,
    input  ready_0, ready_1, ready_2, ready_3
  );

  modport slave (
    input  data_out_0, data_out_1, data_out_2, data_out_3,
    input  valid_0, valid_1, valid_2, valid_3,
    output ready_0, ready_1, ready_2, ready_3
  );
endinterface

// File: rtl/generador_datos.sv
// generador_datos: four-lane word source. On start it emits num_words words per lane
// ({lane_id, seq}, seq counting up from seed) under per-lane valid/ready, counts accepted
// words per lane, then parks in DONE until start falls.
//   clk, rst      : clock, synchronous active-high reset
//   i_start       : level run request, sampled in IDLE only
//   i_num_words   : words per lane, latched in LOAD
//   i_seed        : first sequence value, latched in LOAD
//   io_lanes      : per-lane data_out/valid (out) and ready (in)
//   o_sent_0..3   : accepted-word count per lane
//   o_estado      : state code IDLE=0 LOAD=1 SEND=2 DONE=4 (feeds the receive-side counter)
//   o_busy/o_done : high in LOAD/SEND, high in DONE
//   o_error       : stall-timeout abort flag
// Optional feature: define GENERADOR_TIMEOUT_EN to abort a run when any lane stalls
// 15 consecutive cycles; otherwise SEND waits forever and o_error is tied low.
module generador_datos #(
  parameter int unsigned SEED_W = 8,
  parameter int unsigned CNT_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [CNT_W-1:0]      i_num_words,
  input  logic [SEED_W-1:0]     i_seed,
  generador_datos_if.master     io_lanes,
  output logic [CNT_W-1:0]      o_sent_0,
  output logic [CNT_W-1:0]      o_sent_1,
  output logic [CNT_W-1:0]      o_sent_2,
  output logic [CNT_W-1:0]      o_sent_3,
  output logic [3:0]            o_estado,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StLoad = 4'd1,
    StSend = 4'd2,
    StDone = 4'd4
  } state_e;

  state_e              r_state, w_state_d;
  logic                r_busy, r_done;
  logic [CNT_W-1:0]    r_num;
  logic [3:0]          r_valid;
  logic [SEED_W-1:0]   r_seq   [4];
  logic [CNT_W-1:0]    r_sent  [4];
  logic [SEED_W+1:0]   r_data  [4];
  logic [3:0]          w_ready, w_xfer;
  logic                w_all_done, w_timeout;

  assign w_ready    = {io_lanes.ready_3, io_lanes.ready_2, io_lanes.ready_1, io_lanes.ready_0};
  assign w_xfer     = r_valid & w_ready;
  // valid only ever drops on a lane's final transfer (or abort), so in SEND it marks completion
  assign w_all_done = ~|r_valid;

`ifdef GENERADOR_TIMEOUT_EN
  logic [3:0] r_stall [4];
  logic       r_error;

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst || (r_state != StSend)) begin
        r_stall[k] <= '0;
      end else if (r_valid[k] && !w_ready[k]) begin
        r_stall[k] <= r_stall[k] + 4'd1;
      end else begin
        r_stall[k] <= '0;
      end
    end
  end

  always_comb begin
    w_timeout = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (r_stall[k] == 4'd15) w_timeout = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_error <= 1'b0;
    end else if (r_state == StLoad) begin
      r_error <= 1'b0;
    end else if ((r_state == StSend) && w_timeout) begin
      r_error <= 1'b1;
    end
  end

  assign o_error = r_error;
`else
  assign w_timeout = 1'b0;
  assign o_error   = 1'b0;
`endif

  // State register plus registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_busy  <= (w_state_d == StLoad) || (w_state_d == StSend);
      r_done  <= (w_state_d == StDone);
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (i_start) w_state_d = StLoad;
      StLoad:  w_state_d = (i_num_words == '0) ? StDone : StSend;
      StSend:  if (w_timeout || w_all_done) w_state_d = StDone;
      StDone:  if (!i_start) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Lane datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num   <= '0;
      r_valid <= '0;
      for (int k = 0; k < 4; k++) begin
        r_seq[k]  <= '0;
        r_sent[k] <= '0;
        r_data[k] <= '0;
      end
    end else begin
      case (r_state)
        StLoad: begin
          r_num <= i_num_words;
          for (int k = 0; k < 4; k++) begin
            r_sent[k] <= '0;
            r_seq[k]  <= i_seed;
            if (i_num_words != '0) begin
              r_valid[k] <= 1'b1;
              r_data[k]  <= {2'(k), i_seed};
            end
          end
        end
        StSend: begin
          for (int k = 0; k < 4; k++) begin
            if (w_xfer[k]) begin
              r_sent[k] <= r_sent[k] + 1'b1;
              r_seq[k]  <= r_seq[k] + 1'b1;
              // last word stays on data_out after acceptance
              if ((r_sent[k] + 1'b1) == r_num) begin
                r_valid[k] <= 1'b0;
              end else begin
                r_data[k] <= {2'(k), SEED_W'(r_seq[k] + 1'b1)};
              end
            end
          end
          // abort overrides; transfers completing on this edge are still counted
          if (w_timeout) r_valid <= '0;
        end
        default: r_valid <= '0;
      endcase
    end
  end

  assign io_lanes.valid_0    = r_valid[0];
  assign io_lanes.valid_1    = r_valid[1];
  assign io_lanes.valid_2    = r_valid[2];
  assign io_lanes.valid_3    = r_valid[3];
  assign io_lanes.data_out_0 = r_data[0];
  assign io_lanes.data_out_1 = r_data[1];
  assign io_lanes.data_out_2 = r_data[2];
  assign io_lanes.data_out_3 = r_data[3];
  assign o_sent_0            = r_sent[0];
  assign o_sent_1            = r_sent[1];
  assign o_sent_2            = r_sent[2];
  assign o_sent_3            = r_sent[3];
  assign o_estado            = r_state;
  assign o_busy              = r_busy;
  assign o_done              = r_done;

endmodule

// File: tb/tb_generador_datos.sv
// tb_generador_datos: scoreboard bench for generador_datos. Each run pushes the expected
// words per lane; a negedge monitor pops and compares on every valid&&ready and checks
// that a stalled lane holds its word. Directed checks cover state sequence and counts.
module tb_generador_datos;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] num_words = '0;
  logic [7:0] seed = '0;
  logic [4:0] sent_0, sent_1, sent_2, sent_3;
  logic [3:0] estado;
  logic       busy, done, error;

  int n_tests = 0;
  int n_fail  = 0;
  int any_valid_seen = 0;

  logic [9:0] exp_q [4][$];

  generador_datos_if u_if ();

  generador_datos u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .i_num_words (num_words),
    .i_seed      (seed),
    .io_lanes    (u_if),
    .o_sent_0    (sent_0),
    .o_sent_1    (sent_1),
    .o_sent_2    (sent_2),
    .o_sent_3    (sent_3),
    .o_estado    (estado),
    .o_busy      (busy),
    .o_done      (done),
    .o_error     (error)
  );

  always #5 clk = ~clk;

  logic [3:0] mon_valid, mon_ready;
  logic [9:0] mon_data [4];
  assign mon_valid = {u_if.valid_3, u_if.valid_2, u_if.valid_1, u_if.valid_0};
  assign mon_ready = {u_if.ready_3, u_if.ready_2, u_if.ready_1, u_if.ready_0};
  assign mon_data[0] = u_if.data_out_0;
  assign mon_data[1] = u_if.data_out_1;
  assign mon_data[2] = u_if.data_out_2;
  assign mon_data[3] = u_if.data_out_3;

  logic any_out;
  assign any_out = |{estado, mon_valid, u_if.data_out_0, u_if.data_out_1, u_if.data_out_2,
                     u_if.data_out_3, sent_0, sent_1, sent_2, sent_3, busy, done, error};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input int lanes, input int num, input logic [7:0] sd);
    for (int k = 0; k < lanes; k++) begin
      for (int i = 0; i < num; i++) exp_q[k].push_back({2'(k), 8'(sd + i)});
    end
  endtask

  task automatic check_q_empty(input string name);
    for (int k = 0; k < 4; k++) check(name, exp_q[k].size(), 0);
  endtask

  // Monitor: transfers and stall stability, sampled mid-cycle.
  logic [3:0] held_v = '0;
  logic [9:0] held_d [4];
  always @(negedge clk) begin
    if (rst) begin
      held_v <= '0;
    end else begin
      if (|mon_valid) any_valid_seen++;
      for (int k = 0; k < 4; k++) begin
        if (held_v[k]) begin
          check("stall_valid_hold", mon_valid[k], 1'b1);
          check("stall_data_hold", mon_data[k], held_d[k]);
        end
        if (mon_valid[k] && mon_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL lane%0d_unexpected_word: got %0h expected none", k, mon_data[k]);
          end else begin
            check("lane_word", mon_data[k], exp_q[k].pop_front());
          end
        end
        held_v[k] <= mon_valid[k] && !mon_ready[k];
        held_d[k] <= mon_data[k];
      end
    end
  end

  // Start, expect LOAD then SEND, wait for DONE and check the cycle count and totals.
  task automatic run(input string name, input logic [4:0] num, input logic [7:0] sd,
                     input int exp_cycles);
    int cnt;
    num_words = num;
    seed      = sd;
    push_run(4, num, sd);
    start = 1'b1;
    step();
    check({name, "_estado_load"}, estado, 4'd1);
    check({name, "_busy_load"}, busy, 1'b1);
    start = 1'b0;
    step();
    check({name, "_estado_send"}, estado, 4'd2);
    check({name, "_valid_first"}, mon_valid, 4'hF);
    check({name, "_lane2_first"}, u_if.data_out_2, {2'd2, sd});
    cnt = 0;
    while (!done && cnt < 60) begin
      step();
      cnt++;
    end
    check({name, "_cycles_to_done"}, cnt, exp_cycles);
    check({name, "_estado_done"}, estado, 4'd4);
    check({name, "_sent"}, {sent_3, sent_2, sent_1, sent_0}, {4{num}});
    check({name, "_error"}, error, 1'b0);
    check_q_empty({name, "_q_empty"});
    step();
    check({name, "_back_idle"}, estado, 4'd0);
  endtask

  initial begin
    int cnt;
    u_if.ready_0 = 1'b1;
    u_if.ready_1 = 1'b1;
    u_if.ready_2 = 1'b1;
    u_if.ready_3 = 1'b1;

    // Reset then idle.
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("idle_outputs_zero", any_out, 1'b0);
      step();
    end

    // Full throughput: 5 words, seed 0x10; DONE one edge after the valid drop.
    run("full", 5'd5, 8'h10, 6);

    // Backpressure on lane 1 for the first four SEND cycles.
    num_words = 5'd3;
    seed      = 8'hA0;
    push_run(4, 3, 8'hA0);
    start = 1'b1;
    step();
    start = 1'b0;
    u_if.ready_1 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("bp_others_done", {sent_3, sent_2, sent_0}, {3{5'd3}});
    check("bp_lane1_stalled", sent_1, 5'd0);
    check("bp_still_send", estado, 4'd2);
    check("bp_lane1_word", u_if.data_out_1, 10'h1A0);
    u_if.ready_1 = 1'b1;
    cnt = 0;
    while (!done && cnt < 40) begin
      step();
      cnt++;
    end
    check("bp_cycles_to_done", cnt, 4);
    check("bp_sent_1", sent_1, 5'd3);
    check("bp_last_word_held", u_if.data_out_1, 10'h1A2);
    check_q_empty("bp_q_empty");
    step();

    // Zero words: 0,1,4 with no valid ever.
    any_valid_seen = 0;
    num_words = 5'd0;
    check("zero_estado_idle", estado, 4'd0);
    start = 1'b1;
    step();
    check("zero_estado_load", estado, 4'd1);
    start = 1'b0;
    step();
    check("zero_estado_done", estado, 4'd4);
    check("zero_done", done, 1'b1);
    check("zero_sent", {sent_3, sent_2, sent_1, sent_0}, 20'd0);
    step();
    check("zero_no_valid", any_valid_seen, 0);

    // Reset mid-SEND after 7 transfers; seed near wrap to exercise seq modulo.
    num_words = 5'd20;
    seed      = 8'hF8;
    push_run(4, 20, 8'hF8);
    start = 1'b1;
    step();
    start = 1'b0;
    cnt = 0;
    while (sent_0 != 5'd7 && cnt < 40) begin
      step();
      cnt++;
    end
    check("rst_reached_7", sent_0, 5'd7);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    step();
    check("rst_outputs_zero", any_out, 1'b0);
    rst = 1'b0;
    step();
    run("after_rst", 5'd2, 8'h33, 3);

    // Stall lane 3 forever.
    num_words = 5'd4;
    seed      = 8'h7E;
    push_run(3, 4, 8'h7E);
    u_if.ready_3 = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
`ifdef GENERADOR_TIMEOUT_EN
    cnt = 0;
    while (!done && cnt < 40) begin
      step();
      cnt++;
    end
    check("to_cycles_to_done", cnt, 16);
    check("to_error", error, 1'b1);
    check("to_estado", estado, 4'd4);
    check("to_valid3_dropped", u_if.valid_3, 1'b0);
`else
    for (int i = 0; i < 30; i++) step();
    check("to_estado_send", estado, 4'd2);
    check("to_error", error, 1'b0);
    check("to_valid3_held", u_if.valid_3, 1'b1);
    check("to_data3_held", u_if.data_out_3, 10'h37E);
`endif
    check("to_sent_3", sent_3, 5'd0);
    check("to_sent_others", {sent_2, sent_1, sent_0}, {3{5'd4}});
    check_q_empty("to_q_empty");
    rst = 1'b1;
    step();
    rst = 1'b0;
    u_if.ready_3 = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
